// File: rtl/mult4_share_arbiter.sv
// One shared 4x4 Dadda multiplier behind a round-robin arbiter and a two-stage
// valid/ready pipeline, with responses tagged by requester id.

// Unit-weight 8-bit Kogge-Stone adder for the final two-row sum.
module mult4_prefix_add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3;

  // Shifted-in g=0 / p=1 makes the low positions a plain copy at each level.
  assign g0  = a & b;
  assign p0  = a ^ b;
  assign g1  = g0 | (p0 & {g0[6:0], 1'b0});
  assign p1  = p0 & {p0[6:0], 1'b1};
  assign g2  = g1 | (p1 & {g1[5:0], 2'b00});
  assign p2  = p1 & {p1[5:0], 2'b11};
  assign g3  = g2 | (p2 & {g2[3:0], 4'b0000});
  assign sum = p0 ^ {g3[6:0], 1'b0};
endmodule

// Combinational 4x4 unsigned multiplier: Dadda reduction to two rows, then prefix add.
module mult4_dadda (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0][3:0] pp;
  logic s1_3, c1_4, s1_4, c1_5;
  logic s2_2, c2_3, s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;
  logic [7:0] row_a, row_b;

  // pp[i][j] carries weight 2**(i+j)
  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pp[i][j] = a[i] & b[j];
  end

  // Reduce max column height 4 -> 3
  assign s1_3 = pp[3][0] ^ pp[2][1];
  assign c1_4 = pp[3][0] & pp[2][1];
  assign s1_4 = pp[3][1] ^ pp[2][2];
  assign c1_5 = pp[3][1] & pp[2][2];

  // Reduce 3 -> 2
  assign s2_2 = pp[2][0] ^ pp[1][1];
  assign c2_3 = pp[2][0] & pp[1][1];
  assign s2_3 = s1_3 ^ pp[1][2] ^ pp[0][3];
  assign c2_4 = (s1_3 & pp[1][2]) | (pp[0][3] & (s1_3 ^ pp[1][2]));
  assign s2_4 = s1_4 ^ pp[1][3] ^ c1_4;
  assign c2_5 = (s1_4 & pp[1][3]) | (c1_4 & (s1_4 ^ pp[1][3]));
  assign s2_5 = pp[3][2] ^ pp[2][3] ^ c1_5;
  assign c2_6 = (pp[3][2] & pp[2][3]) | (c1_5 & (pp[3][2] ^ pp[2][3]));

  assign row_a = {1'b0, pp[3][3], s2_5, s2_4, s2_3, s2_2, pp[1][0], pp[0][0]};
  assign row_b = {1'b0, c2_6, c2_5, c2_4, c2_3, pp[0][2], pp[0][1], 1'b0};

  mult4_prefix_add8 u_add (.a(row_a), .b(row_b), .sum(p));
endmodule

// Per-requester operand gate; only the granted lane contributes to the AND-OR mux.
module mult4_share_lane (
  input  logic       grant,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] gx,
  output logic [3:0] gy
);
  assign gx = grant ? x : 4'd0;
  assign gy = grant ? y : 4'd0;
endmodule

module mult4_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_x,
  input  logic [4*NREQ-1:0]    req_y,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [7:0]           resp_prod,
  output logic                 busy,
  output logic [CNTW-1:0]      done_cnt
);
  logic [NREQ-1:0][3:0] lane_x, lane_y, lane_gx, lane_gy;
  logic [IDW-1:0]       rr_ptr, grant_idx, next_ptr;
  logic                 grant_found, accept;
  logic                 s1_v, s2_v, s1_adv, s2_load;
  logic [3:0]           s1_x, s1_y, sel_x, sel_y;
  logic [IDW-1:0]       s1_id;
  logic [7:0]           mult_p;
  int                   t;

  assign lane_x = req_x;
  assign lane_y = req_y;

  assign s2_load = !s2_v || resp_ready;
  assign s1_adv  = !s1_v || s2_load;

  // Round-robin search from rr_ptr upward with wrap-around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    t           = 0;
    for (int off = 0; off < NREQ; off++) begin
      t = int'(rr_ptr) + off;
      if (t >= NREQ) t = t - NREQ;
      if (!grant_found && req_valid[t]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(t);
      end
    end
  end

  // Reset also gates the grant so req_ready reads zero while rst_n is low.
  assign accept    = grant_found && s1_adv && rst_n;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  assign next_ptr  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      mult4_share_lane u_lane (
        .grant (req_ready[gi]),
        .x     (lane_x[gi]),
        .y     (lane_y[gi]),
        .gx    (lane_gx[gi]),
        .gy    (lane_gy[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_x = 4'd0;
    sel_y = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_x = sel_x | lane_gx[i];
      sel_y = sel_y | lane_gy[i];
    end
  end

  mult4_dadda u_mult (.a(s1_x), .b(s1_y), .p(mult_p));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
      s1_id  <= '0;
      rr_ptr <= '0;
    end else if (s1_adv) begin
      s1_v <= accept;
      if (accept) begin
        s1_x   <= sel_x;
        s1_y   <= sel_y;
        s1_id  <= grant_idx;
        rr_ptr <= next_ptr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      resp_id   <= '0;
      resp_prod <= '0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        resp_id   <= s1_id;
        resp_prod <= mult_p;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 done_cnt <= '0;
    else if (s2_v && resp_ready) done_cnt <= done_cnt + CNTW'(1);
  end

  assign resp_valid = s2_v;
  assign busy       = s1_v | s2_v;
endmodule

// File: tb/tb_mult4_share_arbiter.sv
// Directed bench for mult4_share_arbiter: grants, products, backpressure, fairness, reset.
module tb_mult4_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_x = '0, req_y = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [1:0]  resp_id;
  logic [7:0]  resp_prod;
  logic        busy;
  logic [15:0] done_cnt;
  int checks = 0;
  int errors = 0;

  mult4_share_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_prod(resp_prod), .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id got %0d want 0", resp_id); end
    checks++; if (resp_prod !== 8'd0) begin errors++; $display("FAIL rst_resp_prod got %0d want 0", resp_prod); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL rst_done_cnt got %0d want 0", done_cnt); end
    req_valid = '0;
  endtask

  task automatic test_single();
    reset_dut();
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 4'b0100; req_x[11:8] = 4'd3; req_y[11:8] = 4'd5;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_stage1 got v=%b busy=%b want v=0 busy=1", resp_valid, busy); end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_prod !== 8'd15)
      begin errors++; $display("FAIL single_resp got v=%b id=%0d p=%0d want v=1 id=2 p=15", resp_valid, resp_id, resp_prod); end
    @(negedge clk); #1;
    checks++; if (done_cnt !== 16'd1 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_done got cnt=%0d v=%b want cnt=1 v=0", done_cnt, resp_valid); end
  endtask

  task automatic test_corner();
    logic [3:0] exp_x [4];
    logic [3:0] exp_y [4];
    logic [7:0] exp_p [4];
    exp_x = '{4'd0, 4'd15, 4'd1, 4'd8};
    exp_y = '{4'd9, 4'd15, 4'd15, 4'd2};
    exp_p = '{8'd0, 8'd225, 8'd15, 8'd16};
    reset_dut();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      if (k == 0) begin
        for (int i = 0; i < 4; i++) begin req_x[4*i +: 4] = exp_x[i]; req_y[4*i +: 4] = exp_y[i]; end
        req_valid = 4'b1111;
      end
      if (k == 5) req_valid = '0;
      #1;
      if (k < 5) begin
        checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL corner_grant%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      end
      if (k >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((k - 2) % 4) || resp_prod !== exp_p[(k - 2) % 4])
          begin errors++; $display("FAIL corner_resp%0d got v=%b id=%0d p=%0d want v=1 id=%0d p=%0d", k, resp_valid, resp_id, resp_prod, (k - 2) % 4, exp_p[(k - 2) % 4]); end
      end
    end
    @(negedge clk); #1;
    checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL corner_done got %0d want 5", done_cnt); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    @(negedge clk);
    req_x[3:0] = 4'd7; req_y[3:0] = 4'd7; req_x[7:4] = 4'd6; req_y[7:4] = 4'd9;
    req_x[11:8] = 4'd2; req_y[11:8] = 4'd3;
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b want 0010", req_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full%0d got %b want 0000", c, req_ready); end
      checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_prod !== 8'd49)
        begin errors++; $display("FAIL bp_hold%0d got v=%b id=%0d p=%0d want v=1 id=0 p=49", c, resp_valid, resp_id, resp_prod); end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100 || resp_prod !== 8'd49) begin errors++; $display("FAIL bp_release got rdy=%b p=%0d want rdy=0100 p=49", req_ready, resp_prod); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_prod !== 8'd54)
      begin errors++; $display("FAIL bp_second got v=%b id=%0d p=%0d want v=1 id=1 p=54", resp_valid, resp_id, resp_prod); end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_prod !== 8'd6)
      begin errors++; $display("FAIL bp_third got v=%b id=%0d p=%0d want v=1 id=2 p=6", resp_valid, resp_id, resp_prod); end
    @(negedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || done_cnt !== 16'd3) begin errors++; $display("FAIL bp_done got v=%b cnt=%0d want v=0 cnt=3", resp_valid, done_cnt); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      req_valid = (c == 0) ? 4'b0010 : 4'b1010;
      #1;
      checks++; if (req_ready !== exp_g[c]) begin errors++; $display("FAIL fair_grant%0d got %b want %b", c, req_ready, exp_g[c]); end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (done_cnt !== 16'd5 || busy !== 1'b0) begin errors++; $display("FAIL fair_done got cnt=%0d busy=%b want cnt=5 busy=0", done_cnt, busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 4'b0011;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || resp_valid !== 1'b1 || req_ready !== 4'b0000)
      begin errors++; $display("FAIL mid_full got busy=%b v=%b rdy=%b want 1 1 0000", busy, resp_valid, req_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || done_cnt !== 16'd0)
      begin errors++; $display("FAIL mid_reset got v=%b rdy=%b busy=%b cnt=%0d want 0 0000 0 0", resp_valid, req_ready, busy, done_cnt); end
    @(negedge clk);
    req_valid = '0; resp_ready = 1'b1; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_after%0d got v=%b want 0", c, resp_valid); end
    end
  endtask

  task automatic test_throughput();
    int q_id[$];
    int q_p[$];
    int n_resp = 0;
    int id, x, y, eid, ep;
    reset_dut();
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 102; cyc++) begin
      @(negedge clk);
      if (cyc < 100) begin
        id = int'($urandom_range(0, 3)); x = int'($urandom_range(0, 15)); y = int'($urandom_range(0, 15));
        req_valid = 4'b0001 << id;
        req_x[4*id +: 4] = 4'(x); req_y[4*id +: 4] = 4'(y);
        q_id.push_back(id); q_p.push_back(x * y);
      end else req_valid = '0;
      #1;
      if (cyc < 100) begin
        checks++; if (req_ready !== (4'b0001 << id)) begin errors++; $display("FAIL tp_grant%0d got %b want %b", cyc, req_ready, 4'b0001 << id); end
      end
      if (cyc >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || q_id.size() == 0) begin
          errors++; $display("FAIL tp_valid%0d got v=%b want 1", cyc, resp_valid);
        end else begin
          eid = q_id.pop_front(); ep = q_p.pop_front(); n_resp++;
          if (resp_id !== 2'(eid) || resp_prod !== 8'(ep)) begin
            errors++; $display("FAIL tp_resp%0d got id=%0d p=%0d want id=%0d p=%0d", cyc, resp_id, resp_prod, eid, ep);
          end
        end
      end
    end
    @(negedge clk); #1;
    checks++; if (n_resp != 100 || done_cnt !== 16'd100 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL tp_total got n=%0d cnt=%0d v=%b want n=100 cnt=100 v=0", n_resp, done_cnt, resp_valid); end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_corner();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_throughput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult4_share_arbiter.md
Name: mult4_share_arbiter

Overview:
- Shares one combinational 4x4 unsigned multiplier (Dadda tree plus prefix adder) among NREQ requesters.
- Round-robin arbitration selects one requester per cycle; its operands pass through a 2-stage pipeline (operand register, product register).
- Products return on a single response channel tagged with the requester id, using valid/ready backpressure.
- Sits between client blocks and the multiplier; the multiplier itself is instantiated unchanged inside.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response id width; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_x  in  4*NREQ  operand x; requester i uses bits [4i+3:4i]
- req_y  in  4*NREQ  operand y; same packing as req_x
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_id  out  IDW  index of the requester that issued the product
- resp_prod  out  8  x*y, unsigned
- busy  out  1  either pipeline stage holds a valid entry
- done_cnt  out  CNTW  count of completed response handshakes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - s1_v=0, s2_v=0, rr_ptr=0, done_cnt=0.
  - resp_valid=0, resp_id=0, resp_prod=0, req_ready=0, busy=0.
- Stage-2 register (resp_*):
  - Loads when s2_v=0 or resp_ready=1; otherwise holds.
  - A held product never changes while resp_valid=1 and resp_ready=0.
- Stage-1 register (operands and id):
  - Advances when s1_v=0 or stage 2 loads.
  - Define s1_adv as that advance condition.
- Arbitration:
  - Combinational.
  - Search starts at index rr_ptr and proceeds upward with wrap-around.
  - The first i with req_valid[i]=1 wins.
  - req_ready[winner]=s1_adv; all other bits are 0.
  - If no request is valid, or s1_adv=0, req_ready=0.
- Accept (req_valid[i] & req_ready[i] at a rising edge):
  - Stage 1 captures x, y and id=i; s1_v=1.
  - rr_ptr becomes (i+1) mod NREQ.
  - If s1_adv=1 and nothing is accepted, s1_v becomes 0 and rr_ptr is unchanged.
- Stage 1 to stage 2:
  - On advance, the multiplier output for the stage-1 operands is captured into resp_prod.
  - The id moves to resp_id, and s2_v takes the previous s1_v value.
- Latency and throughput:
  - Request accepted at edge N gives resp_valid=1 after edge N+1 with no stall.
  - Sustained throughput is 1 product per cycle when resp_ready stays 1.
- Backpressure:
  - With resp_ready=0, at most 2 entries are held (stage 1 plus stage 2).
  - req_ready stays 0 while both stages are full.
  - No entry is dropped or duplicated.
- Simultaneous events: when stage 2 drains, stage 1 advances and a new request is accepted in the same cycle.
- done_cnt:
  - Increments on each resp_valid & resp_ready.
  - Wraps modulo 2**CNTW.
- busy = s1_v | s2_v.
- Requester protocol:
  - A requester holds req_valid, req_x and req_y stable until accepted.
  - The arbiter does not depend on this but never samples a non-granted requester.
- Reset mid-operation: all in-flight entries are discarded; no response is issued for them after rst_n rises.
- Arithmetic: resp_prod = {4'b0,x} * {4'b0,y}, exact, range 0..225.

Test Plan:
- Single request: requester 2 sends x=3, y=5 with resp_ready=1 → req_ready=4'b0100 in the same cycle; after edge N+1, resp_valid=1, resp_id=2, resp_prod=15, and done_cnt=1 after the handshake.
- Corner values with all requesters continuously valid and rr_ptr=0:
  - Operands (0,9), (15,15), (1,15), (8,2).
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Products are 0, 225, 15, 16 with ids 0, 1, 2, 3.
- Backpressure:
  - resp_ready=0 while requesters 0 and 1 issue 7*7 and 6*9 → req_ready drops to 0 after two accepts and resp_prod holds 49.
  - Raise resp_ready → 49 then 54 delivered in order, then a new accept.
- Fairness: requester 3 valid continuously, requester 1 becomes valid while rr_ptr=2 → grant 3, then 1, then 3. Requester 3 is never granted twice while 1 waits.
- Reset mid-operation: drop rst_n with both stages full → resp_valid, req_ready, busy and done_cnt go to 0 immediately. After release with no requests, resp_valid stays 0.
- Throughput: 100 random requests with resp_ready=1 → 100 responses in 101 cycles, all products exact, ids matching, done_cnt=100.
